// File: rtl/mil_rx_decoder.sv
// MIL-STD-1553 Manchester-II word receiver: sync qualification, bit decode and odd-parity check.
// Latency: rx_valid 2 cycles after the parity bit's second-half sample; inputs add 2 cycles (3 with filter).
// Backpressure: none; each word is strobed once and held. `define MIL_RX_GLITCH_FILTER_EN adds a majority voter.
module mil_rx_decoder #(
    parameter int CLK_PER_BIT = 50,
    parameter int DATA_W      = 16,
    parameter int SYNC_TOL    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_p,
    input  logic              in_n,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_cw,
    output logic              rx_valid,
    output logic              rx_par_err,
    output logic              rx_man_err,
    output logic              rx_busy
);
    localparam int CW = $clog2(2*CLK_PER_BIT+1);
    localparam int BW = $clog2(DATA_W+2);
    localparam int H  = 3*CLK_PER_BIT/2;
    // Distance from DONE to the end of the parity bit: a contiguous next sync whose
    // first half continues the parity bit's second half is measured this much long.
    localparam int CONT_OFF = CLK_PER_BIT - 3*CLK_PER_BIT/4 - 1;

    localparam logic [CW-1:0] RUN_MAX = CW'(2*CLK_PER_BIT);
    localparam logic [CW-1:0] PH_LAST = CW'(CLK_PER_BIT-1);
    localparam logic [CW-1:0] PH_S1   = CW'(CLK_PER_BIT/4);
    localparam logic [CW-1:0] PH_S2   = CW'(3*CLK_PER_BIT/4);
    localparam logic [CW-1:0] RS_LO   = CW'(CLK_PER_BIT/2 - CLK_PER_BIT/8);
    localparam logic [CW-1:0] RS_HI   = CW'(CLK_PER_BIT/2 + CLK_PER_BIT/8);
    localparam logic [CW-1:0] PH_RS   = CW'(CLK_PER_BIT/2 + 1);
    // SYNC_B exits SYNC_TOL-1 cycles before the nominal boundary, which then lands on phase 0.
    localparam logic [CW-1:0] PH_LOAD = CW'(CLK_PER_BIT - SYNC_TOL + 1);
    localparam logic [CW:0]   A_LO    = (CW+1)'(H - SYNC_TOL);
    localparam logic [CW:0]   A_HI    = (CW+1)'(H + SYNC_TOL);
    localparam logic [CW:0]   C_LO    = (CW+1)'(H - SYNC_TOL + CONT_OFF);
    localparam logic [CW:0]   C_HI    = (CW+1)'(H + SYNC_TOL + CONT_OFF);
    localparam logic [CW:0]   C_SHORT = (CW+1)'(CONT_OFF + SYNC_TOL);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W);

    typedef enum logic [1:0] {LV_Z = 2'd0, LV_P = 2'd1, LV_N = 2'd2} lvl_e;
    typedef enum logic [2:0] {ST_IDLE, ST_SYNC_A, ST_SYNC_B, ST_DATA, ST_DONE} state_e;

    logic [1:0] p_sync_q, n_sync_q;
    logic       p_s, n_s;
    lvl_e       lvl;

    // Two-flop synchronisers for the asynchronous line-receiver outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_sync_q <= '0;
            n_sync_q <= '0;
        end else begin
            p_sync_q <= {p_sync_q[0], in_p};
            n_sync_q <= {n_sync_q[0], in_n};
        end
    end

`ifdef MIL_RX_GLITCH_FILTER_EN
    logic [1:0] p_hist_q, n_hist_q;

    // Two-sample history feeding the 3-sample majority voters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_hist_q <= '0;
            n_hist_q <= '0;
        end else begin
            p_hist_q <= {p_hist_q[0], p_sync_q[1]};
            n_hist_q <= {n_hist_q[0], n_sync_q[1]};
        end
    end

    assign p_s = (p_sync_q[1] & p_hist_q[0]) | (p_sync_q[1] & p_hist_q[1]) | (p_hist_q[0] & p_hist_q[1]);
    assign n_s = (n_sync_q[1] & n_hist_q[0]) | (n_sync_q[1] & n_hist_q[1]) | (n_hist_q[0] & n_hist_q[1]);
`else
    assign p_s = p_sync_q[1];
    assign n_s = n_sync_q[1];
`endif

    // Line level decode: only the two complementary combinations are valid polarities
    always_comb begin
        lvl = LV_Z;
        if (p_s && !n_s)      lvl = LV_P;
        else if (!p_s && n_s) lvl = LV_N;
    end

    state_e              state_q, state_d;
    lvl_e                lvl_q, pol_q, pol_d, s1_q, s1_d, opp;
    logic [CW-1:0]       run_q, run_d, phase_q, phase_d;
    logic [CW:0]         run_len, lo, hi;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_W:0]     shift_q, shift_d;
    logic                cont_q, cont_d, chg, bit_ok, bit_val;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_cw_q, rx_cw_d, rx_valid_q, rx_valid_d;
    logic                rx_par_err_q, rx_par_err_d, rx_man_err_q, rx_man_err_d;

    // Next-state and datapath logic for sync qualification and bit decoding
    always_comb begin
        chg          = (lvl != lvl_q);
        run_len      = {1'b0, run_q} + (CW+1)'(1);
        run_d        = chg ? '0 : ((run_q == RUN_MAX) ? run_q : run_q + CW'(1));
        opp          = (pol_q == LV_P) ? LV_N : LV_P;
        lo           = cont_q ? C_LO : A_LO;
        hi           = cont_q ? C_HI : A_HI;
        state_d      = state_q;
        pol_d        = pol_q;
        s1_d         = s1_q;
        cont_d       = cont_q;
        phase_d      = phase_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        bit_ok       = 1'b0;
        bit_val      = 1'b0;
        rx_data_d    = rx_data_q;
        rx_cw_d      = rx_cw_q;
        rx_par_err_d = rx_par_err_q;
        rx_valid_d   = 1'b0;
        rx_man_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (chg && lvl != LV_Z) begin
                    state_d = ST_SYNC_A;
                    pol_d   = lvl;
                    cont_d  = 1'b0;
                end
            end
            ST_SYNC_A: begin
                if (chg) begin
                    cont_d = 1'b0;
                    if (lvl == opp && run_len >= lo && run_len <= hi) begin
                        state_d = ST_SYNC_B;
                    end else if (cont_q && lvl != LV_Z && run_len <= C_SHORT) begin
                        // End of the previous word's parity bit: the real sync starts now
                        pol_d = lvl;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_SYNC_B: begin
                if (chg) begin
                    state_d = ST_IDLE;
                end else if (run_len >= A_LO) begin
                    state_d   = ST_DATA;
                    phase_d   = PH_LOAD;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            ST_DATA: begin
                phase_d = (phase_q == PH_LAST) ? '0 : phase_q + CW'(1);
                if (chg && phase_q >= RS_LO && phase_q <= RS_HI) phase_d = PH_RS;
                if (phase_q == PH_S1) s1_d = lvl;
                if (phase_q == PH_S2) begin
                    if (s1_q == LV_P && lvl == LV_N) begin
                        bit_ok  = 1'b1;
                        bit_val = 1'b1;
                    end else if (s1_q == LV_N && lvl == LV_P) begin
                        bit_ok  = 1'b1;
                    end
                    if (bit_ok) begin
                        shift_d = {shift_q[DATA_W-1:0], bit_val};
                        if (bit_cnt_q == LAST_BIT) state_d = ST_DONE;
                        else bit_cnt_d = bit_cnt_q + BW'(1);
                    end else begin
                        rx_man_err_d = 1'b1;
                        shift_d      = '0;
                        state_d      = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                rx_data_d    = shift_q[DATA_W:1];
                rx_par_err_d = ~(^shift_q);
                rx_cw_d      = (pol_q == LV_P);
                rx_valid_d   = 1'b1;
                run_d        = '0;
                pol_d        = lvl;
                cont_d       = (lvl != LV_Z);
                state_d      = (lvl != LV_Z) ? ST_SYNC_A : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Counters, shift register and held word outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q        <= LV_Z;
            pol_q        <= LV_Z;
            s1_q         <= LV_Z;
            cont_q       <= 1'b0;
            run_q        <= '0;
            phase_q      <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_cw_q      <= 1'b0;
            rx_par_err_q <= 1'b0;
            rx_valid_q   <= 1'b0;
            rx_man_err_q <= 1'b0;
        end else begin
            lvl_q        <= lvl;
            pol_q        <= pol_d;
            s1_q         <= s1_d;
            cont_q       <= cont_d;
            run_q        <= run_d;
            phase_q      <= phase_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            rx_cw_q      <= rx_cw_d;
            rx_par_err_q <= rx_par_err_d;
            rx_valid_q   <= rx_valid_d;
            rx_man_err_q <= rx_man_err_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_cw      = rx_cw_q;
    assign rx_valid   = rx_valid_q;
    assign rx_par_err = rx_par_err_q;
    assign rx_man_err = rx_man_err_q;
    assign rx_busy    = (state_q != ST_IDLE);
endmodule

// File: tb/tb_mil_rx_decoder.sv
// Directed bench for mil_rx_decoder: drives Manchester words on in_p/in_n and checks the strobed results.
module tb_mil_rx_decoder;
    logic        clk = 1'b0;
    logic        rst_n, in_p, in_n;
    logic [15:0] rx_data;
    logic        rx_cw, rx_valid, rx_par_err, rx_man_err, rx_busy;

    always #5 clk = ~clk;

    mil_rx_decoder #(.CLK_PER_BIT(50), .DATA_W(16), .SYNC_TOL(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_p(in_p), .in_n(in_n),
        .rx_data(rx_data), .rx_cw(rx_cw), .rx_valid(rx_valid),
        .rx_par_err(rx_par_err), .rx_man_err(rx_man_err), .rx_busy(rx_busy)
    );

    int          nchk = 0;
    int          nerr = 0;
    int          cyc = 0;
    int          n_man = 0;
    int          n_both = 0;
    logic [15:0] q_dat[$];
    logic        q_cw[$];
    logic        q_pe[$];
    int          q_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe away from the active edge
    always @(negedge clk) begin
        if (rx_valid) begin
            q_dat.push_back(rx_data);
            q_cw.push_back(rx_cw);
            q_pe.push_back(rx_par_err);
            q_cyc.push_back(cyc);
        end
        if (rx_man_err) n_man <= n_man + 1;
        if (rx_valid && rx_man_err) n_both <= n_both + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_word(input string tag, input int idx, input logic [15:0] d,
                              input logic cw, input logic pe);
        check({tag, "_data"}, (q_dat.size() > idx) ? 32'(q_dat[idx]) : 32'hFFFF_FFFF, 32'(d));
        check({tag, "_cw"},   (q_cw.size()  > idx) ? 32'(q_cw[idx])  : 32'hFFFF_FFFF, 32'(cw));
        check({tag, "_pe"},   (q_pe.size()  > idx) ? 32'(q_pe[idx])  : 32'hFFFF_FFFF, 32'(pe));
    endtask

    // l: 0 = Z, 1 = P, 2 = N, held for n cycles
    task automatic drive(input int l, input int n);
        @(negedge clk);
        in_p = (l == 1);
        in_n = (l == 2);
        repeat (n-1) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input int bl, input bit bad);
        if (bad) drive(1, bl);
        else if (b) begin drive(1, bl/2); drive(2, bl - bl/2); end
        else begin drive(2, bl/2); drive(1, bl - bl/2); end
    endtask

    // first: sync first-half length (0 = nominal); badbit: data bit held P (-1 = none)
    task automatic send_word(input logic cmd, input logic [15:0] data, input logic par,
                             input int bl, input int first, input int badbit, input bit glitch);
        int   pa, pb, h1, h2;
        logic b;
        pa = cmd ? 1 : 2;
        pb = cmd ? 2 : 1;
        h1 = (first > 0) ? first : (3*bl)/2;
        h2 = 3*bl - (3*bl)/2;
        if (glitch) begin
            drive(pa, h1/2); drive(0, 1); drive(pa, h1 - h1/2 - 1);
        end else begin
            drive(pa, h1);
        end
        drive(pb, h2);
        for (int i = 0; i < 17; i++) begin
            b = (i < 16) ? data[15-i] : par;
            send_bit(b, bl, (i < 16) && ((15 - i) == badbit));
        end
    endtask

    int base, man0, gap, exp_glitch;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_p = 1'b0; in_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_data",   32'(rx_data),    0);
        check("rst_cw",     32'(rx_cw),      0);
        check("rst_valid",  32'(rx_valid),   0);
        check("rst_pe",     32'(rx_par_err), 0);
        check("rst_man",    32'(rx_man_err), 0);
        check("rst_busy",   32'(rx_busy),    0);
        rst_n = 1'b1;
        drive(0, 20);

        // Command word 0xA5A5, parity 1
        base = q_dat.size();
        send_word(1'b1, 16'hA5A5, 1'b1, 50, 0, -1, 0);
        drive(0, 150);
        check("t1_count", 32'(q_dat.size() - base), 1);
        check_word("t1", base, 16'hA5A5, 1'b1, 1'b0);
        check("t1_hold", 32'(rx_data), 32'h0000A5A5);

        // Data word 0x0000 with wrong parity bit 0
        base = q_dat.size();
        send_word(1'b0, 16'h0000, 1'b0, 50, 0, -1, 0);
        drive(0, 150);
        check("t2_count", 32'(q_dat.size() - base), 1);
        check_word("t2", base, 16'h0000, 1'b0, 1'b1);

        // Manchester violation on bit 5, then a clean 0x1234
        base = q_dat.size(); man0 = n_man;
        send_word(1'b0, 16'h0000, 1'b1, 50, 0, 5, 0);
        drive(0, 150);
        check("t3_man", 32'(n_man - man0), 1);
        check("t3_noval", 32'(q_dat.size() - base), 0);
        base = q_dat.size();
        send_word(1'b0, 16'h1234, 1'b0, 50, 0, -1, 0);
        drive(0, 150);
        check("t3b_count", 32'(q_dat.size() - base), 1);
        check_word("t3b", base, 16'h1234, 1'b0, 1'b0);

        // Back-to-back command 0x8001 and data 0x7FFE
        base = q_dat.size();
        send_word(1'b1, 16'h8001, 1'b1, 50, 0, -1, 0);
        send_word(1'b0, 16'h7FFE, 1'b1, 50, 0, -1, 0);
        drive(0, 150);
        check("t4_count", 32'(q_dat.size() - base), 2);
        check_word("t4a", base,     16'h8001, 1'b1, 1'b0);
        check_word("t4b", base + 1, 16'h7FFE, 1'b0, 1'b0);
        gap = (q_cyc.size() > base + 1) ? q_cyc[base+1] - q_cyc[base] : 0;
        check("t4_gap", 32'((gap >= 998 && gap <= 1002) ? 1000 : gap), 1000);

        // Sync first-half length qualification
        base = q_dat.size();
        send_word(1'b1, 16'h5555, 1'b1, 50, 68, -1, 0);
        drive(0, 150);
        check("t5_68", 32'(q_dat.size() - base), 0);
        send_word(1'b1, 16'h5555, 1'b1, 50, 82, -1, 0);
        drive(0, 150);
        check("t5_82", 32'(q_dat.size() - base), 0);
        send_word(1'b1, 16'h5555, 1'b1, 50, 75, -1, 0);
        drive(0, 150);
        check("t5_75", 32'(q_dat.size() - base), 1);
        check_word("t5", base, 16'h5555, 1'b1, 1'b0);

        // +/-2 % bit-rate drift
        base = q_dat.size(); man0 = n_man;
        send_word(1'b0, 16'hC3A5, 1'b1, 51, 0, -1, 0);
        drive(0, 150);
        send_word(1'b1, 16'h3C5A, 1'b1, 49, 0, -1, 0);
        drive(0, 150);
        check("t6_count", 32'(q_dat.size() - base), 2);
        check("t6_man", 32'(n_man - man0), 0);
        check_word("t6a", base,     16'hC3A5, 1'b0, 1'b0);
        check_word("t6b", base + 1, 16'h3C5A, 1'b1, 1'b0);

        // One-cycle Z glitch inside the sync first half
`ifdef MIL_RX_GLITCH_FILTER_EN
        exp_glitch = 1;
`else
        exp_glitch = 0;
`endif
        base = q_dat.size();
        send_word(1'b1, 16'h0F0F, 1'b1, 50, 0, -1, 1);
        drive(0, 150);
        check("t7_glitch", 32'(q_dat.size() - base), 32'(exp_glitch));

        // Asynchronous reset in the middle of a word
        base = q_dat.size();
        drive(1, 75); drive(2, 75);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 50, 0);
        check("t8_busy", 32'(rx_busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t8_data", 32'(rx_data), 0);
        check("t8_flags", 32'({rx_cw, rx_valid, rx_par_err, rx_man_err, rx_busy}), 0);
        in_p = 1'b0; in_n = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        drive(0, 300);
        check("t8_noval", 32'(q_dat.size() - base), 0);
        send_word(1'b1, 16'hBEEF, 1'b0, 50, 0, -1, 0);
        drive(0, 150);
        check("t8_count", 32'(q_dat.size() - base), 1);
        check_word("t8", base, 16'hBEEF, 1'b1, 1'b0);

        check("valid_man_overlap", 32'(n_both), 0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
